// File: rtl/riscv_pkg.sv
// Shared RV32I encoder types: instruction formats, opcode constants and loader FSM states.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_fmt_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } enc_state_t;

endpackage

// File: rtl/instr_fmt_pack.sv
// Combinational RV32I field-to-word packer with legality flag.
// With INSTR_ENCODER_IMM_CHECK_EN defined, immediates that do not fit their format are also flagged illegal.
module instr_fmt_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        legal
);

  logic fmt_ok_s;
  logic range_ok_s;

  // Format-dependent bit packing; unknown formats produce no word.
  always_comb begin
    instr    = 32'h0000_0000;
    fmt_ok_s = 1'b1;
    case (fmt)
      FMT_R:   instr = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, op};
      FMT_I:   instr = {imm[11:0], rs1, funct3, rd, op};
      FMT_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      FMT_B:   instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
      FMT_U:   instr = {imm[31:12], rd, op};
      FMT_J:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: fmt_ok_s = 1'b0;
    endcase
  end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  // True when v is representable as a signed value of the given bit width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] hi;
    hi = $signed(v) >>> (bits - 32'd1);
    return (hi == 32'sd0) || (hi == -32'sd1);
  endfunction

  // Immediate range check per format.
  always_comb begin
    range_ok_s = 1'b1;
    case (fmt)
      FMT_I, FMT_S: range_ok_s = fits_signed(imm, 32'd12);
      FMT_B:        range_ok_s = fits_signed(imm, 32'd13) & ~imm[0];
      FMT_J:        range_ok_s = fits_signed(imm, 32'd21) & ~imm[0];
      FMT_U:        range_ok_s = (imm[11:0] == 12'h000);
      default:      range_ok_s = 1'b1;
    endcase
  end
`else
  assign range_ok_s = 1'b1;
`endif

  assign legal = fmt_ok_s & range_ok_s;

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder / program loader: FSM, word counter, address generator, output register.
// Optional immediate range checking under INSTR_ENCODER_IMM_CHECK_EN (see instr_fmt_pack).
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned    DEPTH     = 64,
  parameter int unsigned    AW        = 32,
  parameter logic [AW-1:0]  BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_fmt,
  input  logic [6:0]    in_op,
  input  logic [2:0]    in_funct3,
  input  logic          in_funct7b5,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [31:0]   out_instr,
  output logic [15:0]   count,
  output logic          done,
  output logic          err
);

  // 17 bits so DEPTH = 65536 is reachable.
  localparam logic [16:0] DEPTH_C = 17'(DEPTH);

  enc_state_t    state_r, next_state_s;
  logic [16:0]   count_r;
  logic [AW-1:0] next_addr_r;
  logic [AW-1:0] out_addr_r;
  logic [31:0]   out_instr_r;
  logic          out_valid_r;
  logic          err_r;
  logic          accept_s;
  logic          legal_s;
  logic [31:0]   word_s;

  instr_fmt_pack u_pack (
    .fmt      (in_fmt),
    .op       (in_op),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .imm      (in_imm),
    .instr    (word_s),
    .legal    (legal_s)
  );

  assign in_ready = (state_r == LOAD) && (count_r < DEPTH_C) && (!out_valid_r || out_ready);
  assign accept_s = in_valid & in_ready;

  // Next-state logic; clear overrides everything.
  always_comb begin
    next_state_s = state_r;
    if (clear) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = start ? LOAD : IDLE;
        LOAD: begin
          if (accept_s && legal_s && ((count_r + 17'd1) == DEPTH_C)) next_state_s = FULL;
          else next_state_s = LOAD;
        end
        FULL:    next_state_s = FULL;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Output stage, counter, address generator and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_addr_r  <= BASE_ADDR;
      out_instr_r <= 32'h0000_0000;
      next_addr_r <= BASE_ADDR;
      count_r     <= 17'd0;
      err_r       <= 1'b0;
    end else if (clear) begin
      out_valid_r <= 1'b0;
      out_addr_r  <= BASE_ADDR;
      out_instr_r <= 32'h0000_0000;
      next_addr_r <= BASE_ADDR;
      count_r     <= 17'd0;
      err_r       <= 1'b0;
    end else begin
      if (out_valid_r && out_ready) out_valid_r <= 1'b0;
      if (accept_s) begin
        if (legal_s) begin
          out_valid_r <= 1'b1;
          out_instr_r <= word_s;
          out_addr_r  <= next_addr_r;
          next_addr_r <= next_addr_r + AW'(32'd4);
          count_r     <= count_r + 17'd1;
        end else begin
          err_r <= 1'b1;
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_addr  = out_addr_r;
  assign out_instr = out_instr_r;
  assign count     = count_r[15:0];
  assign err       = err_r;
  assign done      = (state_r == FULL) && !out_valid_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4); expectations adapt to INSTR_ENCODER_IMM_CHECK_EN.
module tb_instr_encoder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, clear, in_valid, in_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_op;
  logic        in_funct7b5;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, done, err;
  logic [31:0] out_addr, out_instr;
  logic [15:0] count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int drain_cyc = -1;
  int first_acc;
  logic [31:0] next_exp_addr = 32'h0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];

  instr_encoder #(.DEPTH(4), .AW(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_instr(out_instr), .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every word taken by the memory side must match the queue head.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      drain_cyc = cyc;
      if (exp_instr_q.size() == 0) begin
        check_eq("unexpected_word", 32'd1, 32'd0);
      end else begin
        check_eq("word_addr", out_addr, exp_addr_q.pop_front());
        check_eq("word_instr", out_instr, exp_instr_q.pop_front());
      end
    end
  end

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input bit has_word, input logic [31:0] word);
    bit ok = 1'b0;
    in_fmt = fmt; in_op = op; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_eq("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    last_acc = cyc;
    if (has_word) begin
      exp_addr_q.push_back(next_exp_addr);
      exp_instr_q.push_back(word);
      next_exp_addr += 32'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_instr_q.size() == 0) break;
      @(negedge clk);
    end
    check_eq("queue_empty", 32'(exp_instr_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = 3'd0; in_op = 7'd0; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_out_addr", out_addr, 32'h0);
    check_eq("rst_out_instr", out_instr, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Session 1: four back-to-back words fill DEPTH, fifth bundle is refused.
    pulse_start();
    send(FMT_R, OP_R, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    first_acc = last_acc;
    send(FMT_R, OP_R, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3);
    send(FMT_B, OP_B, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b1, 32'hFE208CE3);
    send(FMT_S, OP_S, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020A423);
    check_eq("back_to_back", 32'(last_acc - first_acc), 32'd3);
    @(negedge clk);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_done", 32'(done), 32'd1);
    check_eq("full_out_valid", 32'(out_valid), 32'd0);
    wait_drain();
    in_valid = 1'b0;

    // Session 2: backpressure stall, same-cycle drain+accept, then clear mid-flight.
    @(posedge clk); #1;
    pulse_clear();
    next_exp_addr = 32'h0;
    pulse_start();
    out_ready = 1'b0;
    send(FMT_J, OP_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h008000EF);
    in_fmt = FMT_U; in_op = OP_LUI; in_rd = 5'd5; in_imm = 32'h1234_5000; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_out_addr", out_addr, 32'h0);
      check_eq("stall_out_instr", out_instr, 32'h008000EF);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(FMT_U, OP_LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h123452B7);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check_eq("release_same_cycle", 32'(drain_cyc), 32'(last_acc));
    check_eq("pre_clear_count", 32'(count), 32'd2);
    check_eq("pre_clear_out_valid", 32'(out_valid), 32'd1);
    pulse_clear();
    @(negedge clk);
    check_eq("clear_out_valid", 32'(out_valid), 32'd0);
    check_eq("clear_count", 32'(count), 32'd0);
    check_eq("clear_in_ready", 32'(in_ready), 32'd0);
    check_eq("clear_done", 32'(done), 32'd0);
    check_eq("clear_stale_word", 32'(exp_instr_q.size()), 32'd1);
    exp_addr_q.delete();
    exp_instr_q.delete();
    next_exp_addr = 32'h0;

    // Session 3: illegal format, out-of-range immediate, first word at BASE_ADDR.
    @(posedge clk); #1;
    pulse_start();
    out_ready = 1'b1;
    send(3'd7, OP_R, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0);
    check_eq("illegal_err", 32'(err), 32'd1);
    check_eq("illegal_count", 32'(count), 32'd0);
    check_eq("illegal_out_valid", 32'(out_valid), 32'd0);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    send(FMT_I, OP_I, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2048, 1'b0, 32'h0);
    check_eq("imm_range_count", 32'(count), 32'd0);
`else
    send(FMT_I, OP_I, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2048, 1'b1, 32'h80008093);
    check_eq("imm_trunc_count", 32'(count), 32'd1);
`endif
    send(FMT_U, OP_LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h123452B7);
    in_valid = 1'b0;
    wait_drain();
    check_eq("err_sticky", 32'(err), 32'd1);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    check_eq("final_count", 32'(count), 32'd1);
    check_eq("final_addr", out_addr, 32'h0);
`else
    check_eq("final_count", 32'(count), 32'd2);
    check_eq("final_addr", out_addr, 32'h4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential RV32I instruction encoder and program loader. It is the encode-side counterpart to the core's op/funct3/funct7b5 control decode.
- Accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit instruction words.
- Emits each word with a sequential instruction-memory address through a one-entry registered output stage with backpressure.
- Used by the bench and boot path to fill instruction memory before the core runs.

Parameters:
- DEPTH, 64, max words written per load session (1..2^16)
- AW, 32, output address width
- BASE_ADDR, 0, byte address of first word; word k at BASE_ADDR + 4*k

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; IDLE -> LOAD
- clear  in  1  pulse; abort session, return to IDLE
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid & in_ready
- in_fmt  in  3  format: R=0 I=1 S=2 B=3 U=4 J=5; 6,7 illegal
- in_op  in  7  opcode
- in_funct3  in  3  funct3
- in_funct7b5  in  1  funct7 bit 5 (R format only)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  sign-extended immediate
- out_valid  out  1  word pending
- out_ready  in  1  memory side takes word when out_valid & out_ready
- out_addr  out  AW  byte address
- out_instr  out  32  encoded word
- count  out  16  words accepted this session
- done  out  1  FULL and output drained
- err  out  1  sticky error flag

Behaviour:
- Reset values: state=IDLE; in_ready, out_valid, done, err = 0; count=0; out_addr=BASE_ADDR; out_instr=0.
- States and transitions:
  - IDLE -(start)-> LOAD.
  - LOAD -(accept making count==DEPTH)-> FULL.
  - Any state -(clear)-> IDLE on the next edge.
  - clear beats start and beats an in-flight accept.
  - start outside IDLE is ignored.
- in_ready = (state==LOAD) & (count<DEPTH) & (!out_valid | out_ready). It is combinational, so full throughput is possible when a drain and an accept happen in the same cycle.
- Latency: bundle accepted at edge N -> out_valid=1 with out_instr/out_addr stable after N. Outputs hold until out_ready.
- Word k uses out_addr = BASE_ADDR + 4*k, truncated to AW bits. Wrap-around is allowed and not flagged.
- Encoding, bit fields of in_imm:
  - Every format: [6:0]=op.
  - R: {1'b0, funct7b5, 5'b0, rs2, rs1, f3, rd}.
  - I: {imm[11:0], rs1, f3, rd}. For srai the caller sets imm[10].
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0]}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}.
  - U: {imm[31:12], rd}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd}.
- Illegal fmt is consumed, produces no word, leaves count unchanged, and sets err.
- count increments only when a word is produced.
- FULL: in_ready=0; the pending word still drains. done = (state==FULL) & !out_valid.
- clear or reset mid-operation:
  - The pending word is discarded (out_valid=0).
  - count=0, err=0, next address back to BASE_ADDR.
- out_valid rises only by accept, so no word is written in IDLE.

Optional Feature:
- Macro INSTR_ENCODER_IMM_CHECK_EN.
- Defined: the immediate range is checked before encoding. A bundle whose immediate does not fit its format is consumed, produces no word, and sets err. Limits:
  - I/S: signed 12-bit.
  - B: signed 13-bit with bit0=0.
  - J: signed 21-bit with bit0=0.
  - U: imm[11:0]=0.
- Undefined: no check; out-of-range bits are silently dropped. err comes only from illegal fmt.

Decomposition:
- riscv_pkg holds:
  - typedef enum logic [2:0] instr_fmt_t (FMT_R..FMT_J).
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JAL, OP_LUI.
  - typedef enum enc_state_t {IDLE, LOAD, FULL}.
- Sub-module instr_fmt_pack: purely combinational field-to-word packing, plus the range check under the macro.
- instr_encoder holds the FSM, counter, address generator and output register.

Test Plan:
- start; R add x3,x1,x2 (op 0110011, f3 0, f7b5 0) -> out_instr 0x002081B3, out_addr 0x0. Then sub with f7b5=1 -> 0x402081B3, addr 0x4.
- B beq x1,x2,imm=-8 -> 0xFE208CE3. S sw x2,8(x1) (f3 010) -> 0x0020A423. J jal x1,8 -> 0x008000EF.
- DEPTH=4, out_ready=1, 5 back-to-back bundles -> 4 words at 0x0..0xC, one per cycle; in_ready=0 after the 4th; done=1 once drained.
- out_ready held 0 for 3 cycles with a word pending -> out_instr/out_addr stable, in_ready=0. Release -> next bundle accepted the same cycle.
- clear while out_valid=1 and count=2 -> next cycle out_valid=0, count=0, state IDLE. After start, first word at BASE_ADDR.
- in_fmt=7 -> no word, err=1, count unchanged. With the macro: I-type imm=2048 -> err=1, no word. Without the macro: word 0x80008093-style encoding produced with imm truncated.
